// File: rtl/id_pkg.sv
// Shared definitions for the ID-stage instruction queue: entry layout,
// NOP encoding and width helpers.
package id_pkg;

    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam int          INST_W_DEF = 32;
    localparam int          PC_W_DEF   = 32;

    // Entry layout, MSB first: {exc, pc, inst}
    typedef struct packed {
        logic                  exc;
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
    } id_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int entry_width(input int inst_w, input int pc_w);
        return inst_w + pc_w + 1;
    endfunction

endpackage

// File: rtl/id_queue_ram.sv
// Queue storage: DEPTH x W register array, one synchronous write port and
// an asynchronous read port that serves the queue head.
module id_queue_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 65,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/id_inst_queue.sv
// Fetch-to-decode instruction queue with delay-slot tracking, branch
// redirect (keeps the delay slot) and full exception flush.
module id_inst_queue
    import id_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              redirect,
    input  logic              inValid,
    output logic              inReady,
    input  logic [INST_W-1:0] inInst,
    input  logic [PC_W-1:0]   inPC,
    input  logic              inExc,
    output logic              outValid,
    input  logic              outReady,
    output logic [INST_W-1:0] outInst,
    output logic [PC_W-1:0]   outPC,
    output logic              outExc,
    output logic              outBd,
    input  logic              popIsBranch,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int ENT_W = entry_width(INST_W, PC_W);

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] cnt;
    logic             bd_next;
    logic [PC_W-1:0]  last_pc;
    logic [ENT_W-1:0] wdata, rdata;
    logic             push, pop, keep_slot, we;

    assign inReady  = (cnt != CNT_W'(DEPTH));
    assign outValid = (cnt != '0);
    assign push     = inValid & inReady;
    assign pop      = outValid & outReady;

    // Redirect with younger entries present: only the delay slot survives,
    // so anything fetched this cycle is wrong-path.
    assign keep_slot = redirect & pop & (cnt >= CNT_W'(2));
    assign we        = push & ~flush & ~keep_slot;
    assign wdata     = {inExc, inPC, inInst};

    id_queue_ram #(
        .DEPTH (DEPTH),
        .W     (ENT_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (tail),
        .wdata (wdata),
        .raddr (head),
        .rdata (rdata)
    );

    assign outInst = outValid ? rdata[INST_W-1:0] : INST_W'(NOP_INST);
    assign outPC   = outValid ? rdata[INST_W +: PC_W] : last_pc;
    assign outExc  = outValid & rdata[ENT_W-1];
    assign outBd   = outValid & bd_next;
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            bd_next <= 1'b0;
            last_pc <= '0;
        end else begin
            last_pc <= outPC;
            if (flush) begin
                cnt     <= '0;
                head    <= tail;
                bd_next <= 1'b0;
            end else begin
                if (pop) begin
                    head    <= head + PTR_W'(1);
                    bd_next <= popIsBranch;
                end
                if (keep_slot) begin
                    tail <= head + PTR_W'(2);
                    cnt  <= CNT_W'(1);
                end else begin
                    if (we) begin
                        tail <= tail + PTR_W'(1);
                    end
                    case ({we, pop})
                        2'b10:   cnt <= cnt + CNT_W'(1);
                        2'b01:   cnt <= cnt - CNT_W'(1);
                        default: cnt <= cnt;
                    endcase
                end
            end
        end
    end

    redirect_needs_pop: assert property (
        @(posedge clk) disable iff (rst) (redirect && !flush) |-> pop
    );

endmodule

// File: tb/tb_id_inst_queue.sv
// Randomised and directed bench for id_inst_queue against a queue-based
// reference model.
module tb_id_inst_queue;

    logic        clk = 1'b0;
    logic        rst, flush, redirect, inValid, inReady, inExc;
    logic [31:0] inInst, inPC;
    logic        outValid, outReady, outExc, outBd, popIsBranch;
    logic [31:0] outInst, outPC;
    logic [2:0]  count;

    id_inst_queue #(.DEPTH(4), .INST_W(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .redirect(redirect),
        .inValid(inValid), .inReady(inReady), .inInst(inInst), .inPC(inPC),
        .inExc(inExc), .outValid(outValid), .outReady(outReady),
        .outInst(outInst), .outPC(outPC), .outExc(outExc), .outBd(outBd),
        .popIsBranch(popIsBranch), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
    } ent_t;

    ent_t        q[$];
    logic        m_bd;
    logic [31:0] m_last_pc;
    logic        m_pushed, m_popped;
    logic [31:0] m_pop_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic f, input logic r, input logic iv, input logic [31:0] ii,
                       input logic [31:0] pc, input logic ie, input logic ordy, input logic pib);
        flush = f; redirect = r; inValid = iv; inInst = ii; inPC = pc;
        inExc = ie; outReady = ordy; popIsBranch = pib;
    endtask

    function automatic logic [31:0] exp_pc();
        return (q.size() != 0) ? q[0].pc : m_last_pc;
    endfunction

    task automatic compare_all();
        logic v;
        v = (q.size() != 0);
        check("outValid", outValid, v);
        check("inReady",  inReady, q.size() != 4);
        check("count",    count, q.size());
        check("outInst",  outInst, v ? q[0].inst : 32'h0);
        check("outPC",    outPC, exp_pc());
        check("outExc",   outExc, v ? q[0].exc : 1'b0);
        check("outBd",    outBd, v & m_bd);
    endtask

    // One clock: compare outputs, then advance the model across the edge.
    task automatic step();
        logic pu, po;
        ent_t e, keep;
        int   n;
        #1 compare_all();
        @(posedge clk);
        n  = q.size();
        pu = inValid && (n != 4);
        po = (n != 0) && outReady;
        e.inst = inInst; e.pc = inPC; e.exc = inExc;
        m_pushed = 1'b0; m_popped = 1'b0; m_pop_pc = 32'h0;
        if (rst) begin
            q.delete(); m_bd = 1'b0; m_last_pc = 32'h0;
        end else begin
            m_last_pc = exp_pc();
            if (flush) begin
                q.delete(); m_bd = 1'b0;
            end else if (redirect && po) begin
                m_popped = 1'b1; m_pop_pc = q[0].pc;
                m_bd = popIsBranch;
                if (n >= 2) begin
                    keep = q[1];
                    q.delete();
                    q.push_back(keep);
                end else begin
                    q.delete();
                    if (pu) begin q.push_back(e); m_pushed = 1'b1; end
                end
            end else begin
                if (po) begin
                    m_popped = 1'b1; m_pop_pc = q[0].pc;
                    void'(q.pop_front());
                    m_bd = popIsBranch;
                end
                if (pu) begin q.push_back(e); m_pushed = 1'b1; end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] push_log[$];
        logic [31:0] pop_log[$];
        int          idx, cyc;
        logic        ordy, pib, r;

        m_bd = 1'b0; m_last_pc = 32'h0;
        rst = 1'b1;
        drv(0, 0, 1, 32'hDEAD_BEEF, 32'h4, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        step();
        check("rst_outInst", outInst, 32'h0);
        check("rst_inReady", inReady, 1'b1);
        rst = 1'b0;

        // First push lands at the head one cycle later
        drv(0, 0, 1, 32'h2401_0001, 32'hBFC0_0000, 0, 0, 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("first_valid", outValid, 1'b1);
        check("first_inst",  outInst, 32'h2401_0001);
        check("first_count", count, 3'd1);
        check("first_bd",    outBd, 1'b0);

        // Fill to DEPTH, then a held 5th push, then pop with push pending
        for (int i = 1; i < 4; i++) begin
            drv(0, 0, 1, 32'h1000 + i, 32'hBFC0_0000 + 4 * i, 0, 0, 0); step();
        end
        check("full_count", count, 3'd4);
        check("full_ready", inReady, 1'b0);
        drv(0, 0, 1, 32'h5555, 32'hBFC0_0010, 0, 0, 0); step();
        check("held_count", count, 3'd4);
        drv(0, 0, 1, 32'h5555, 32'hBFC0_0010, 0, 1, 0); step();
        check("pop_full_count", count, 3'd3);

        // Redirect with younger entries: keep delay slot only
        drv(1, 0, 0, 0, 0, 0, 0, 0); step();
        drv(0, 0, 1, 32'h1022_0003, 32'h100, 0, 0, 0); step();
        drv(0, 0, 1, 32'h0022_1820, 32'h104, 0, 0, 0); step();
        drv(0, 0, 1, 32'h0022_1822, 32'h108, 0, 0, 0); step();
        drv(0, 0, 1, 32'h0022_1825, 32'h10C, 0, 0, 0); step();
        drv(0, 1, 0, 0, 0, 0, 1, 1); step();
        check("redir_count", count, 3'd1);
        check("redir_pc",    outPC, 32'h104);
        check("redir_bd",    outBd, 1'b1);
        drv(0, 0, 1, 32'h0022_1826, 32'h110, 0, 1, 0); step();
        check("after_slot_pc", outPC, 32'h110);
        check("after_slot_bd", outBd, 1'b0);

        // Redirect with a single entry keeps the same-cycle push
        drv(1, 0, 0, 0, 0, 0, 0, 0); step();
        drv(0, 0, 1, 32'h1022_0003, 32'h200, 0, 0, 0); step();
        drv(0, 1, 1, 32'h0, 32'h204, 0, 1, 1); step();
        check("redir1_count", count, 3'd1);
        check("redir1_pc",    outPC, 32'h204);
        check("redir1_bd",    outBd, 1'b1);

        // Flush beats push and pop
        drv(1, 0, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 1, 32'hA000 + i, 32'h300 + 4 * i, i[0], 0, 0); step();
        end
        drv(1, 0, 1, 32'hBBBB, 32'h30C, 0, 1, 0); step();
        check("flush_count", count, 3'd0);
        check("flush_valid", outValid, 1'b0);
        check("flush_inst",  outInst, 32'h0);
        check("flush_bd",    outBd, 1'b0);

        // Ordered stream across pointer wrap
        idx = 0; cyc = 0;
        while (pop_log.size() < 20 && cyc < 400) begin
            drv(0, 0, (idx < 20) && ($urandom % 4 != 0), 32'hC000 + idx,
                32'h1000 + 4 * idx, 0, $urandom % 2, 0);
            step();
            if (m_pushed) begin push_log.push_back(32'h1000 + 4 * idx); idx++; end
            if (m_popped) pop_log.push_back(m_pop_pc);
            cyc++;
        end
        check("stream_pops", pop_log.size(), 20);
        for (int i = 0; i < pop_log.size() && i < push_log.size(); i++)
            check("stream_order", pop_log[i], push_log[i]);

        // Random traffic including redirects and flushes
        for (int i = 0; i < 400; i++) begin
            ordy = $urandom % 2;
            pib  = ($urandom % 4 == 0);
            r    = pib && ordy && (q.size() != 0) && ($urandom % 2 == 1);
            drv(($urandom % 25) == 0, r, $urandom % 3 != 0, $urandom,
                $urandom & 32'hFFFF_FFFC, ($urandom % 8) == 0, ordy, pib);
            step();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised instruction buffer between fetch and decode. It replaces the single ID pipeline register with a DEPTH-entry circular queue.
- Ready/valid handshake on both sides.
- Tracks branch delay slots: marks the instruction after a branch as bd, and on a branch redirect keeps that delay slot while discarding younger wrong-path entries.
- Supports a full exception flush. The head entry feeds the existing decoder and operand muxing directly.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- INST_W, 32, instruction width.
- PC_W, 32, PC width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  exception/eret flush; discard everything.
- redirect  in  1  branch taken/resolved in ID; valid only together with a pop.
- inValid  in  1  fetch offers an entry.
- inReady  out  1  queue accepts the entry.
- inInst  in  INST_W  fetched instruction.
- inPC  in  PC_W  its PC.
- inExc  in  1  fetch-side exception (address error / TLB miss) attached to the entry.
- outValid  out  1  head entry valid.
- outReady  in  1  decode consumes the head (= ~stall).
- outInst  out  INST_W  head instruction; 0 (NOP) when outValid=0.
- outPC  out  PC_W  head PC; holds the last value when empty.
- outExc  out  1  head exception flag; 0 when empty.
- outBd  out  1  head is in a branch delay slot.
- popIsBranch  in  1  decoder reports that the head being popped is a branch or jump.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst=1 at a clock edge): count=0, pointers=0, bdNext=0. Outputs: outValid=0, outInst=0, outExc=0, outBd=0, inReady=1. outPC is reset to 0.
- Priority: rst > flush > redirect > normal push/pop.
- Push: occurs when inValid & inReady. inReady = (count != DEPTH). A same-cycle pop does not raise inReady; there is no pass-through credit.
- Pop: occurs when outValid & outReady. outValid = (count != 0).
- Latency: an entry pushed into an empty queue appears at the head the next cycle. There is no combinational in-to-out path.
- Outputs are driven from storage[head]. When empty, outInst and outExc are forced to 0.
- Pointers wrap modulo DEPTH. count updates +1 / -1 / 0 for push, pop, or both together.
- bd tracking:
  - Register bdNext, with outBd = bdNext & outValid.
  - On every pop, bdNext <= popIsBranch.
  - flush clears bdNext. redirect does not clear it, so the delay slot keeps bd=1.
- flush:
  - Next cycle: count=0, head=tail, bdNext=0.
  - A push presented in the flush cycle is dropped, even if inReady=1.
  - A pop in the flush cycle is ignored.
- redirect (asserted only with a pop of a branch; redirect without a pop is illegal and asserted against in simulation):
  - If count >= 2 before the pop, keep only the entry after the popped one (the delay slot). Next cycle count=1 and any same-cycle push is dropped.
  - If count == 1 before the pop, a push in the same cycle is retained as the delay slot, giving count=1. With no push, count=0, and the frontend guarantees that its first post-redirect push is the delay slot.
- Full and empty: a push while full is never accepted. A pop while empty is impossible (outValid=0).
- Simultaneous push and pop while full: only the pop occurs; count becomes DEPTH-1.

Decomposition:
- Package id_pkg holds:
  - NOP_INST = 0;
  - the entry struct layout {exc, pc, inst}, of width INST_W+PC_W+1;
  - localparam helpers for pointer width ($clog2(DEPTH)).
- One sub-module, id_queue_ram: DEPTH x entry register array with a write port (we, waddr, wdata) and an async read port at head. Pointer, counter, bd and flush/redirect control stay in id_inst_queue.

Test Plan:
- Reset, then push 0x24010001 @PC 0xBFC00000 with outReady=0 -> next cycle outValid=1, outInst=0x24010001, count=1, outBd=0. During reset, outInst=0 and inReady=1.
- Fill with outReady=0 and DEPTH=4, pushing 4 entries -> count=4, inReady=0. A 5th push is held. One pop with inValid=1 -> count=3 and the 5th entry is not accepted that cycle.
- With queue {BEQ@0x100, ADD@0x104, SUB@0x108, OR@0x10C}: pop BEQ with popIsBranch=1 and redirect=1 -> next cycle count=1, head PC=0x104, outBd=1. Popping ADD with popIsBranch=0 -> the following head has outBd=0.
- With only BEQ in the queue, pop it with redirect=1 while pushing NOP@0x104 -> next cycle count=1, outPC=0x104, outBd=1.
- With a 3-entry queue, assert flush together with a push and a pop -> next cycle count=0, outValid=0, outInst=0, outBd=0. The pushed entry is absent.
- Wrap-around: stream 20 entries with random outReady -> output order and PCs match input order exactly, and no entry is lost or duplicated across pointer wrap.
